// File: rtl/eth_avst_rx_gate_pkg.sv
// Shared types and helpers for the RX AVST frame-boundary gate.
package eth_avst_rx_gate_pkg;

    // Frame tracking state: between frames, inside a forwarded frame,
    // inside a dropped frame.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASS    = 2'd1,
        DISCARD = 2'd2
    } gate_state_t;

    // Width of the EOF_POS field (index of the last valid byte in a word).
    function automatic int unsigned eof_pos_width(input int unsigned data_width);
        int unsigned bytes;
        bytes = data_width / 8;
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/eth_avst_rx_gate_sat_cnt.sv
// Saturating event counter with synchronous clear; clear has priority
// over a same-cycle increment.
module eth_avst_rx_gate_sat_cnt #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Count up on inc, stick at all-ones, clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/eth_avst_rx_gate.sv
// Frame-boundary gate for the RX AVST stream. Opens/closes the stream under
// software control, applying changes only at frame starts, drops words
// outside frames and flags framing errors.
// Optional statistics counters: define ETH_AVST_RX_GATE_STATS_EN.
module eth_avst_rx_gate
    import eth_avst_rx_gate_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic                                 CTRL_ENABLE,
    output logic                                 STATUS_ENABLED,
    input  logic [DATA_WIDTH-1:0]                IN_AVST_DATA,
    input  logic                                 IN_AVST_SOF,
    input  logic                                 IN_AVST_EOF,
    input  logic [eof_pos_width(DATA_WIDTH)-1:0] IN_AVST_EOF_POS,
    input  logic                                 IN_AVST_UNDERSIZED,
    input  logic                                 IN_AVST_SRC_RDY,
    output logic [DATA_WIDTH-1:0]                OUT_AVST_DATA,
    output logic                                 OUT_AVST_SOF,
    output logic                                 OUT_AVST_EOF,
    output logic [eof_pos_width(DATA_WIDTH)-1:0] OUT_AVST_EOF_POS,
    output logic                                 OUT_AVST_UNDERSIZED,
    output logic                                 OUT_AVST_SRC_RDY,
    input  logic                                 STAT_CLEAR,
    output logic [CNT_WIDTH-1:0]                 STAT_PASSED,
    output logic [CNT_WIDTH-1:0]                 STAT_DISCARDED,
    output logic [CNT_WIDTH-1:0]                 STAT_ERRORS
);

    gate_state_t state;
    gate_state_t state_nxt;
    logic        fwd_word;
    logic        inc_passed;
    logic        inc_discarded;
    logic        inc_error;

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, forward decision and statistic events for the current word.
    // A SOF is always re-decided from CTRL_ENABLE, whatever the current state;
    // seeing it outside IDLE means the previous frame lost its EOF.
    always_comb begin
        state_nxt     = state;
        fwd_word      = 1'b0;
        inc_passed    = 1'b0;
        inc_discarded = 1'b0;
        inc_error     = 1'b0;
        if (IN_AVST_SRC_RDY) begin
            if (IN_AVST_SOF) begin
                inc_error     = (state != IDLE);
                fwd_word      = CTRL_ENABLE;
                inc_discarded = ~CTRL_ENABLE;
                inc_passed    = CTRL_ENABLE & IN_AVST_EOF;
                if (IN_AVST_EOF) begin
                    state_nxt = IDLE;
                end else if (CTRL_ENABLE) begin
                    state_nxt = PASS;
                end else begin
                    state_nxt = DISCARD;
                end
            end else begin
                case (state)
                    IDLE: begin
                        inc_error = IN_AVST_EOF;
                    end
                    PASS: begin
                        fwd_word = 1'b1;
                        if (IN_AVST_EOF) begin
                            state_nxt  = IDLE;
                            inc_passed = 1'b1;
                        end
                    end
                    DISCARD: begin
                        if (IN_AVST_EOF) begin
                            state_nxt = IDLE;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                    end
                endcase
            end
        end
    end

    // Applied gate state follows the request only while between frames.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            STATUS_ENABLED <= 1'b0;
        end else if (state == IDLE) begin
            STATUS_ENABLED <= CTRL_ENABLE;
        end
    end

    // Registered output stream; payload fields only load on forwarded words.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OUT_AVST_DATA       <= '0;
            OUT_AVST_SOF        <= 1'b0;
            OUT_AVST_EOF        <= 1'b0;
            OUT_AVST_EOF_POS    <= '0;
            OUT_AVST_UNDERSIZED <= 1'b0;
            OUT_AVST_SRC_RDY    <= 1'b0;
        end else begin
            OUT_AVST_SRC_RDY    <= fwd_word;
            OUT_AVST_SOF        <= fwd_word & IN_AVST_SOF;
            OUT_AVST_EOF        <= fwd_word & IN_AVST_EOF;
            OUT_AVST_UNDERSIZED <= fwd_word & IN_AVST_UNDERSIZED;
            if (fwd_word) begin
                OUT_AVST_DATA    <= IN_AVST_DATA;
                OUT_AVST_EOF_POS <= IN_AVST_EOF_POS;
            end
        end
    end

`ifdef ETH_AVST_RX_GATE_STATS_EN
    eth_avst_rx_gate_sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt_passed (
        .clk (CLK),
        .rst (RESET),
        .clr (STAT_CLEAR),
        .inc (inc_passed),
        .cnt (STAT_PASSED)
    );

    eth_avst_rx_gate_sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt_discarded (
        .clk (CLK),
        .rst (RESET),
        .clr (STAT_CLEAR),
        .inc (inc_discarded),
        .cnt (STAT_DISCARDED)
    );

    eth_avst_rx_gate_sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt_errors (
        .clk (CLK),
        .rst (RESET),
        .clr (STAT_CLEAR),
        .inc (inc_error),
        .cnt (STAT_ERRORS)
    );
`else
    assign STAT_PASSED    = '0;
    assign STAT_DISCARDED = '0;
    assign STAT_ERRORS    = '0;

    logic unused_stats;
    assign unused_stats = ^{STAT_CLEAR, inc_passed, inc_discarded, inc_error};
`endif

endmodule

// File: doc/eth_avst_rx_gate.md
# eth_avst_rx_gate

Frame-boundary gate and sequencer for the RX MAC lite receive path, placed directly in front of the AVST-to-MFB shakedown adapter. It opens or closes the single-region AVST stream under software control, and applies a change only between frames, so the adapter never sees a partial frame. It also drops words that fall outside any frame, flags framing errors, and optionally keeps saturating frame statistics.

## Interface
Parameters:
- DATA_WIDTH, 512: AVST data width in bits; must be a multiple of 8.
- CNT_WIDTH, 32: width of each statistics counter.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, asynchronous, active-high.
- CTRL_ENABLE  in  1  software gate request: 1 passes frames, 0 discards them.
- STATUS_ENABLED  out  1  gate state actually applied.
- IN_AVST_DATA  in  DATA_WIDTH  data word.
- IN_AVST_SOF  in  1  start of frame.
- IN_AVST_EOF  in  1  end of frame.
- IN_AVST_EOF_POS  in  log2(DATA_WIDTH/8)  index of the last valid byte.
- IN_AVST_UNDERSIZED  in  1  undersized-frame flag, valid with EOF.
- IN_AVST_SRC_RDY  in  1  word valid. There is no backpressure and no DST_RDY input.
- OUT_AVST_DATA / SOF / EOF / EOF_POS / UNDERSIZED / SRC_RDY  out  same widths as the inputs  gated stream.
- STAT_CLEAR  in  1  synchronous clear of all counters.
- STAT_PASSED  out  CNT_WIDTH  frames forwarded.
- STAT_DISCARDED  out  CNT_WIDTH  frames discarded because the gate was closed.
- STAT_ERRORS  out  CNT_WIDTH  framing errors.

## Operation
- FSM states: IDLE (between frames), PASS (inside a forwarded frame), DISCARD (inside a dropped frame). Input words are considered only when IN_AVST_SRC_RDY=1.
- IDLE + SOF:
  - The frame is decided from CTRL_ENABLE in the same cycle: 1 means PASS and the word is forwarded; 0 means DISCARD and the word is dropped.
  - If EOF is also set (single-word frame), the FSM stays in IDLE.
- IDLE + word without SOF: the word is dropped. If the word carries EOF, STAT_ERRORS is incremented.
- PASS: words are forwarded. EOF moves the FSM to IDLE and increments STAT_PASSED.
- DISCARD: words are dropped. EOF moves the FSM to IDLE.
- SOF while in PASS or DISCARD (missing EOF):
  - STAT_ERRORS is incremented.
  - The word is treated as a new frame start and re-decided exactly as in IDLE.
  - The unterminated previous frame is not repaired; the downstream adapter handles it.
- STAT_DISCARDED increments on the SOF of each discarded frame.
- STATUS_ENABLED register: loaded from CTRL_ENABLE on every cycle in which the FSM is in IDLE at the start of the cycle; held otherwise.
- UNDERSIZED, EOF_POS and DATA pass through unmodified with forwarded words.
- Counters saturate at 2^CNT_WIDTH−1. When STAT_CLEAR and an increment occur in the same cycle, the clear wins and that increment is lost.

## Timing
- Latency: 1 cycle; every output is registered.
- Dropped words give OUT_AVST_SRC_RDY=0 in the corresponding output cycle.
- Reset values: all OUT_AVST_* = 0, STATUS_ENABLED = 0, all counters = 0, FSM = IDLE.
- Reset asserted mid-frame: after release, remaining words of that frame have no SOF and are dropped as out-of-frame. Their EOF counts one error.
- CTRL_ENABLE toggling mid-frame has no effect until the next SOF.

## Configuration
- Macro ETH_AVST_RX_GATE_STATS_EN.
- Defined: the three saturating counters are implemented as described.
- Undefined: STAT_PASSED, STAT_DISCARDED and STAT_ERRORS are tied to 0, STAT_CLEAR is ignored, and no counter logic is built. Gating behaviour is identical in both cases.

## Structure
- Package eth_avst_rx_gate_pkg contains:
  - the FSM state enum typedef (IDLE, PASS, DISCARD);
  - a function returning the EOF_POS width from DATA_WIDTH.
- Sub-module eth_avst_rx_gate_sat_cnt: a saturating counter with increment and synchronous clear, parameterized by CNT_WIDTH. It is instantiated three times, inside the ETH_AVST_RX_GATE_STATS_EN guard.

## Test plan
- ENABLE=1, three 4-word frames back to back -> all 12 words appear 1 cycle later; STAT_PASSED=3; the other counters stay 0.
- ENABLE=1, ENABLE dropped to 0 at word 2 of a 4-word frame, then a 2-word frame -> the first frame is forwarded complete, the second produces no output; STAT_PASSED=1, STAT_DISCARDED=1; STATUS_ENABLED falls after the first EOF.
- ENABLE=1, single-word frame (SOF=EOF=1, EOF_POS=5, UNDERSIZED=1) -> one output word with identical flags; STAT_PASSED=1.
- SOF, data, SOF (no EOF), data, EOF -> all words are forwarded; STAT_ERRORS=1, STAT_PASSED=1. Then an orphan EOF in IDLE -> that word is dropped; STAT_ERRORS=2.
- Counters preset near max (CNT_WIDTH=4, 16 passed frames) -> STAT_PASSED holds at 15; STAT_CLEAR asserted on an EOF cycle gives STAT_PASSED=0.
- Assert RESET mid-frame -> outputs go to 0 immediately; after release, the frame tail is dropped and STAT_ERRORS=1.
